// File: rtl/sw_hw_xfer_pkg.sv
// Shared types for the software/hardware byte-transfer block: FSM states,
// handshake encodings and the byte-slot helper.
package sw_hw_xfer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RX_WAIT  = 3'd0;
  localparam state_t RX_ACK   = 3'd1;
  localparam state_t RX_REL   = 3'd2;
  localparam state_t AES_WAIT = 3'd3;
  localparam state_t TX_SEND  = 3'd4;
  localparam state_t TX_ACK   = 3'd5;
  localparam state_t TX_REL   = 3'd6;
  localparam state_t ERR      = 3'd7;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'b00,
    HS_VALID = 2'b01,
    HS_ACK   = 2'b10,
    HS_ERR   = 2'b11
  } hs_e;

  localparam int XFER_BYTES = 16;

  // Byte 0 is the most significant byte of a 128-bit word.
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/xfer_watchdog.sv
// Handshake watchdog: down-counter reloaded on clear, flags expiry at terminal count.
// Instantiated by sw_hw_xfer only when XFER_TIMEOUT_EN is defined.
module xfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Reload leaves two cycles of slack so the FSM lands in ERR exactly
  // TIMEOUT_CYCLES cycles after the stalled state was entered.
  localparam logic [CW-1:0] LOAD = CW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);

  logic [CW-1:0] remaining;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= LOAD;
    end else if (clear) begin
      remaining <= LOAD;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign expired = enable && !clear && (remaining == '0);

endmodule

// File: rtl/sw_hw_xfer.sv
// Byte-serial handshake bridge between software and an AES controller.
// Optional handshake watchdog enabled by defining XFER_TIMEOUT_EN.
//
// state    | meaning
// RX_WAIT  | waiting for software byte (cnt selects key/msg slot)
// RX_ACK   | byte taken, waiting for software to release
// RX_REL   | reserved encoding, never entered
// AES_WAIT | key/msg complete, io_ready high until aes_ready
// TX_SEND  | present result byte cnt
// TX_ACK   | waiting for software result-byte ack
// TX_REL   | waiting for software release, then next byte
// ERR      | watchdog expired, waiting for idle handshake
module sw_hw_xfer
  import sw_hw_xfer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   to_hw_sig,
  input  logic [7:0]   to_hw_port,
  output logic [1:0]   to_sw_sig,
  output logic [7:0]   to_sw_port,
  output logic [127:0] key,
  output logic [127:0] msg_en,
  output logic         io_ready,
  input  logic [127:0] msg_de,
  input  logic         aes_ready
);

  state_t       state;
  logic [4:0]   cnt;
  logic [127:0] result;

`ifdef XFER_TIMEOUT_EN
  state_t prev_state;
  logic   wd_enable;
  logic   wd_clear;
  logic   wd_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_state <= RX_WAIT;
    else          prev_state <= state;
  end

  // Any state change is handshake progress, so the timer restarts.
  assign wd_enable = (state == RX_ACK) || (state == TX_SEND) || (state == TX_ACK) ||
                     (state == TX_REL) || ((state == RX_WAIT) && (cnt != 5'd0));
  assign wd_clear  = !wd_enable || (state != prev_state);

  xfer_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_WAIT;
      cnt        <= 5'd0;
      to_sw_sig  <= HS_IDLE;
      to_sw_port <= 8'h00;
      io_ready   <= 1'b0;
      key        <= '0;
      msg_en     <= '0;
      result     <= '0;
    end else begin
`ifdef XFER_TIMEOUT_EN
      if (wd_expired) begin
        state     <= ERR;
        to_sw_sig <= HS_ERR;
      end else
`endif
      case (state)
        RX_WAIT: if (to_hw_sig == HS_VALID) begin
          if (!cnt[4]) key[byte_lsb(cnt[3:0]) +: 8]    <= to_hw_port;
          else         msg_en[byte_lsb(cnt[3:0]) +: 8] <= to_hw_port;
          to_sw_sig <= HS_VALID;
          state     <= RX_ACK;
        end
        RX_ACK: if (to_hw_sig == HS_IDLE) begin
          to_sw_sig <= HS_IDLE;
          cnt       <= cnt + 5'd1;
          state     <= (cnt == 5'd31) ? AES_WAIT : RX_WAIT;
        end
        AES_WAIT: if (aes_ready) begin
          result   <= msg_de;
          io_ready <= 1'b0;
          state    <= TX_SEND;
        end else begin
          io_ready <= 1'b1;
        end
        TX_SEND: begin
          to_sw_port <= result[byte_lsb(cnt[3:0]) +: 8];
          to_sw_sig  <= HS_ACK;
          state      <= TX_ACK;
        end
        TX_ACK: if (to_hw_sig == HS_ACK) begin
          to_sw_sig <= HS_IDLE;
          state     <= TX_REL;
        end
        TX_REL: if (to_hw_sig == HS_IDLE) begin
          if (cnt == 5'(XFER_BYTES - 1)) begin
            cnt   <= 5'd0;
            state <= RX_WAIT;
          end else begin
            cnt   <= cnt + 5'd1;
            state <= TX_SEND;
          end
        end
`ifdef XFER_TIMEOUT_EN
        ERR: if (to_hw_sig == HS_IDLE) begin
          to_sw_sig <= HS_IDLE;
          cnt       <= 5'd0;
          state     <= RX_WAIT;
        end
`endif
        default: state <= RX_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_hw_xfer.sv
// Directed self-checking bench for sw_hw_xfer; the watchdog scenario runs
// when XFER_TIMEOUT_EN is defined, otherwise a stall must never raise 11.
module tb_sw_hw_xfer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   to_hw_sig = 2'b00;
  logic [7:0]   to_hw_port = 8'h00;
  logic [1:0]   to_sw_sig;
  logic [7:0]   to_sw_port;
  logic [127:0] key;
  logic [127:0] msg_en;
  logic         io_ready;
  logic [127:0] msg_de = '0;
  logic         aes_ready = 1'b0;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RES1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] MSG2 = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;

  sw_hw_xfer #(.TIMEOUT_CYCLES(1000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .to_hw_sig  (to_hw_sig),
    .to_hw_port (to_hw_port),
    .to_sw_sig  (to_sw_sig),
    .to_sw_port (to_sw_port),
    .key        (key),
    .msg_en     (msg_en),
    .io_ready   (io_ready),
    .msg_de     (msg_de),
    .aes_ready  (aes_ready)
  );

  always #5 clk = ~clk;

  task automatic wait_sig(input logic [1:0] exp, input string what);
    int n = 0;
    while (to_sw_sig !== exp && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (to_sw_sig !== exp) begin
      total++; bad++;
      $display("FAIL %s timeout: to_sw_sig=%b required %b", what, to_sw_sig, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold_chk);
    to_hw_port = b;
    to_hw_sig  = 2'b01;
    wait_sig(2'b01, "rx_taken");
    if (hold_chk) begin
      to_hw_port = ~b;
      repeat (2) @(negedge clk);
      total++;
      if (to_sw_sig !== 2'b01) begin
        bad++;
        $display("FAIL rx_hold: to_sw_sig=%b required 01", to_sw_sig);
      end
    end
    to_hw_sig = 2'b00;
    wait_sig(2'b00, "rx_release");
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] m, input bit hold_chk);
    for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], hold_chk);
    for (int i = 0; i < 16; i++) send_byte(m[127-8*i -: 8], hold_chk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    to_hw_sig = 2'b00;
    aes_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 5;
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL reset_sig: got %b required 00", to_sw_sig); end
    if (to_sw_port !== 8'h00) begin bad++; $display("FAIL reset_port: got %h required 00", to_sw_port); end
    if (key !== '0) begin bad++; $display("FAIL reset_key: got %h required 0", key); end
    if (msg_en !== '0) begin bad++; $display("FAIL reset_msg: got %h required 0", msg_en); end
    if (io_ready !== 1'b0) begin bad++; $display("FAIL reset_io_ready: got %b required 0", io_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rx();
    send_block(KEY1, MSG1, 1'b1);
    @(negedge clk);
    total += 3;
    if (key !== KEY1) begin bad++; $display("FAIL rx_key: got %h required %h", key, KEY1); end
    if (msg_en !== MSG1) begin bad++; $display("FAIL rx_msg: got %h required %h", msg_en, MSG1); end
    if (io_ready !== 1'b1) begin bad++; $display("FAIL rx_io_ready: got %b required 1", io_ready); end
  endtask

  task automatic test_aes();
    repeat (100) @(negedge clk);
    total++;
    if (io_ready !== 1'b1) begin bad++; $display("FAIL aes_hold_io_ready: got %b required 1", io_ready); end
    msg_de = RES1;
    aes_ready = 1'b1;
    @(negedge clk);
    aes_ready = 1'b0;
    total++;
    if (io_ready !== 1'b0) begin bad++; $display("FAIL aes_io_drop: got %b required 0", io_ready); end
    for (int i = 0; i < 16; i++) begin
      wait_sig(2'b10, "tx_valid");
      total++;
      if (to_sw_port !== RES1[127-8*i -: 8])
        begin bad++; $display("FAIL tx_byte%0d: got %h required %h", i, to_sw_port, RES1[127-8*i -: 8]); end
      if (i == 0) begin
        to_hw_sig = 2'b11;
        repeat (3) @(negedge clk);
        total += 2;
        if (to_sw_sig !== 2'b10) begin bad++; $display("FAIL tx_ack_ignore11_sig: got %b required 10", to_sw_sig); end
        if (to_sw_port !== 8'h00) begin bad++; $display("FAIL tx_ack_ignore11_port: got %h required 00", to_sw_port); end
      end
      to_hw_sig = 2'b10;
      wait_sig(2'b00, "tx_ack");
      to_hw_sig = 2'b00;
      @(negedge clk);
    end
    @(negedge clk);
    total += 3;
    if (key !== KEY1) begin bad++; $display("FAIL retain_key: got %h required %h", key, KEY1); end
    if (msg_en !== MSG1) begin bad++; $display("FAIL retain_msg: got %h required %h", msg_en, MSG1); end
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL tx_done_sig: got %b required 00", to_sw_sig); end
  endtask

  task automatic test_rx_ignore();
    to_hw_port = 8'hAA;
    to_hw_sig = 2'b11;
    repeat (3) @(negedge clk);
    total += 2;
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL rx_ignore11_sig: got %b required 00", to_sw_sig); end
    if (key !== KEY1) begin bad++; $display("FAIL rx_ignore11_key: got %h required %h", key, KEY1); end
    to_hw_sig = 2'b00;
    msg_de = 128'hdeadbeef;
    aes_ready = 1'b1;
    @(negedge clk);
    aes_ready = 1'b0;
    repeat (3) @(negedge clk);
    total += 2;
    if (io_ready !== 1'b0) begin bad++; $display("FAIL aes_ignored_io_ready: got %b required 0", io_ready); end
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL aes_ignored_sig: got %b required 00", to_sw_sig); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i), 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    total += 5;
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL mid_reset_sig: got %b required 00", to_sw_sig); end
    if (to_sw_port !== 8'h00) begin bad++; $display("FAIL mid_reset_port: got %h required 00", to_sw_port); end
    if (key !== '0) begin bad++; $display("FAIL mid_reset_key: got %h required 0", key); end
    if (msg_en !== '0) begin bad++; $display("FAIL mid_reset_msg: got %h required 0", msg_en); end
    if (io_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_io_ready: got %b required 0", io_ready); end
    reset_n = 1'b1;
    @(negedge clk);
    send_block(KEY2, MSG2, 1'b0);
    @(negedge clk);
    total += 3;
    if (key !== KEY2) begin bad++; $display("FAIL post_reset_key: got %h required %h", key, KEY2); end
    if (msg_en !== MSG2) begin bad++; $display("FAIL post_reset_msg: got %h required %h", msg_en, MSG2); end
    if (io_ready !== 1'b1) begin bad++; $display("FAIL post_reset_io_ready: got %b required 1", io_ready); end
  endtask

`ifdef XFER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0);
    while (to_sw_sig !== 2'b11 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 1000) begin bad++; $display("FAIL timeout_cycle: got %0d required 1000", n); end
    to_hw_sig = 2'b00;
    @(negedge clk);
    total++;
    if (to_sw_sig !== 2'b00) begin bad++; $display("FAIL err_exit_sig: got %b required 00", to_sw_sig); end
    send_byte(8'h5A, 1'b0);
    total++;
    if (key[127:120] !== 8'h5A) begin bad++; $display("FAIL err_exit_cnt0: got %h required 5a", key[127:120]); end
  endtask
`else
  task automatic test_no_timeout();
    bit seen11 = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0);
    repeat (1200) begin
      @(negedge clk);
      if (to_sw_sig === 2'b11) seen11 = 1'b1;
    end
    total++;
    if (seen11 || to_sw_sig !== 2'b00)
      begin bad++; $display("FAIL no_timeout: to_sw_sig=%b seen11=%0b required 00 and never 11", to_sw_sig, seen11); end
    send_byte(8'h5A, 1'b0);
    total++;
    if (key[95:88] !== 8'h5A) begin bad++; $display("FAIL stall_resume_slot4: got %h required 5a", key[95:88]); end
  endtask
`endif

  initial begin
    test_reset();
    test_rx();
    test_aes();
    test_rx_ignore();
    test_reset_mid();
`ifdef XFER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_hw_xfer.md
SW_HW_XFER -- requirements
Module: sw_hw_xfer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, handshake watchdog limit in clk cycles (used only with XFER_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock (CLOCK_50 domain).
REQ-003 SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port to_hw_sig  input  2  software handshake: 00 idle, 01 byte valid, 10 result-byte ack, 11 illegal.
REQ-005 SHALL have port to_hw_port  input  8  software data byte.
REQ-006 SHALL have port to_sw_sig  output  2  hardware handshake: 00 idle, 01 byte taken, 10 result byte valid, 11 error.
REQ-007 SHALL have port to_sw_port  output  8  result data byte.
REQ-008 SHALL have port key  output  128  assembled AES key.
REQ-009 SHALL have port msg_en  output  128  assembled ciphertext.
REQ-010 SHALL have port io_ready  output  1  key and msg_en complete, request to AES controller.
REQ-011 SHALL have port msg_de  input  128  decrypted result from AES controller.
REQ-012 SHALL have port aes_ready  input  1  msg_de valid.

Function
REQ-013 SHALL implement FSM states RX_WAIT, RX_ACK, RX_REL, AES_WAIT, TX_SEND, TX_ACK, TX_REL, ERR.
REQ-014 RX_WAIT: on to_hw_sig==01, SHALL latch to_hw_port into byte slot cnt, drive to_sw_sig=01, go RX_ACK next cycle.
REQ-015 Slot order SHALL be: cnt 0..15 -> key[127-8*cnt -: 8]; cnt 16..31 -> msg_en[127-8*(cnt-16) -: 8]; cnt is 5-bit.
REQ-016 RX_ACK: wait to_hw_sig==00, then drive to_sw_sig=00, increment cnt; if cnt was 31 go AES_WAIT with cnt wrapping to 0, else RX_WAIT.
REQ-017 AES_WAIT: io_ready SHALL be 1 (registered, asserted the cycle after entry) and held until aes_ready==1 sampled; that cycle SHALL capture msg_de internally, drop io_ready, go TX_SEND.
REQ-018 TX_SEND: to_sw_port SHALL present result byte cnt (msg_de[127-8*cnt -: 8]), to_sw_sig=10, go TX_ACK.
REQ-019 TX_ACK: on to_hw_sig==10 drive to_sw_sig=00, go TX_REL; TX_REL: on to_hw_sig==00 increment cnt; after byte 15 go RX_WAIT, else TX_SEND.
REQ-020 to_hw_sig==11 in any state SHALL be ignored (no latch, no state change).
REQ-021 Handshake values other than the awaited one SHALL hold state; latched byte SHALL not change during RX_ACK.
REQ-022 key and msg_en SHALL retain values after a transfer until overwritten by the next one.
REQ-023 aes_ready outside AES_WAIT SHALL be ignored.

Reset
REQ-024 On reset_n low (any state, mid-transfer included): state RX_WAIT, cnt 0, to_sw_sig 00, to_sw_port 00, io_ready 0, key 0, msg_en 0, captured result 0.

Configuration
REQ-025 Macro XFER_TIMEOUT_EN defined: watchdog counts cycles in RX_ACK, TX_SEND/TX_ACK/TX_REL, RX_WAIT with cnt!=0; reaching TIMEOUT_CYCLES SHALL go ERR with to_sw_sig=11; ERR exits to RX_WAIT, cnt 0, when to_hw_sig==00 for one cycle.
REQ-026 Macro XFER_TIMEOUT_EN undefined: no watchdog logic, ERR unreachable, to_sw_sig never 11.

Structure
REQ-027 Package sw_hw_xfer_pkg SHALL hold state enum, handshake encodings (HS_IDLE, HS_VALID, HS_ACK, HS_ERR), XFER_BYTES=16.
REQ-028 Watchdog SHALL be sub-module xfer_watchdog (clear, enable, expired), instantiated only under XFER_TIMEOUT_EN.

Verification
REQ-029 Send key 000102..0f then msg 69c4e0d8..c55a -> key=0x000102030405060708090a0b0c0d0e0f, msg_en=0x69c4e0d86a7b0430d8cdb78070b4c55a, io_ready=1.
REQ-030 Model aes_ready after 100 cycles with msg_de=0x00112233445566778899aabbccddeeff -> io_ready drops, 16 bytes 00,11,..,ff returned in order.
REQ-031 Assert reset_n low after byte 7 -> all outputs 0, next transfer starting at byte 0 assembles correctly.
REQ-032 Drive to_hw_sig=11 during RX_WAIT and TX_ACK -> no state change, no byte latched.
REQ-033 Pulse aes_ready during RX_WAIT -> ignored; io_ready stays 0.
REQ-034 With XFER_TIMEOUT_EN, TIMEOUT_CYCLES=1000, stall after byte 3 -> to_sw_sig=11 at cycle 1000; to_hw_sig=00 -> RX_WAIT, cnt 0.
